// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - Shared types and constants for the instruction fetch unit
package ifu_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_VALID,
        S_DRAIN
    } state_t;

    // addi x0, x0, 0: the instruction handed to decode alongside a fault flag
    localparam logic [31:0] NOP_INST         = 32'h00000013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h80000000;

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - Fetch unit bus: imem request/response channel plus decode handshake
// Signals:
//   imem_req_valid/ready/addr       one word read request per instruction
//   imem_rsp_valid/data/err         single-cycle response per accepted request
//   inst_valid/ready, inst, inst_pc instruction handoff to decode/execute
// Modports: master = fetch unit, slave = memory and decode side.
interface ifu_fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            imem_rsp_err;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - Multi-cycle instruction fetch unit owning the architectural PC
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   bus                ifu_fetch_if.master: imem request/response and decode handshake
//   next_pc            PC of the following instruction, taken when inst is consumed
//   flush_valid/pc     trap/xret redirect, overrides every other event
//   fetch_cnt          count of delivered instructions, wraps at 2^32
//   inst_fault         only with IFU_FAULT_EN: fault flag travelling with inst
// Build option IFU_FAULT_EN: misaligned PCs and imem access faults are turned into
// a NOP with inst_fault set; without it the low address bits are forced to zero
// and imem_rsp_err is ignored.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    ifu_fetch_if.master     bus,
    input  logic [XLEN-1:0] next_pc,
    input  logic            flush_valid,
    input  logic [XLEN-1:0] flush_pc,
    output logic [31:0]     fetch_cnt
`ifdef IFU_FAULT_EN
    ,
    output logic            inst_fault
`endif
);

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            accept;
    logic            fire;
    logic            misaligned;

`ifdef IFU_FAULT_EN
    assign misaligned        = (pc[1:0] != 2'b00);
    assign bus.imem_req_addr = pc;
`else
    logic unused_rsp_err;
    assign unused_rsp_err    = bus.imem_rsp_err;
    assign misaligned        = 1'b0;
    assign bus.imem_req_addr = {pc[XLEN-1:2], 2'b00};
`endif

    // Gating with rst keeps the request low during reset even though state is S_REQ.
    assign bus.imem_req_valid = rst && (state == S_REQ) && !misaligned;
    assign bus.inst_valid     = (state == S_VALID);
    assign accept             = bus.imem_req_valid && bus.imem_req_ready;
    assign fire               = bus.inst_valid && bus.inst_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            bus.inst  <= '0;
            bus.inst_pc <= RESET_PC;
            fetch_cnt <= '0;
`ifdef IFU_FAULT_EN
            inst_fault <= 1'b0;
`endif
        end else if (flush_valid) begin
            pc <= flush_pc;
            unique case (state)
                // An accepted request still owes us a response that must be swallowed.
                S_REQ:   state <= accept ? S_DRAIN : S_REQ;
                S_WAIT:  state <= bus.imem_rsp_valid ? S_REQ : S_DRAIN;
                S_VALID: state <= S_REQ;
                // The outstanding response can land together with a second flush;
                // it still retires the drain, otherwise nothing would ever end it.
                S_DRAIN: state <= bus.imem_rsp_valid ? S_REQ : S_DRAIN;
                default: state <= S_REQ;
            endcase
        end else begin
            unique case (state)
                S_REQ: begin
                    if (misaligned) begin
                        bus.inst    <= XLEN'(NOP_INST);
                        bus.inst_pc <= pc;
`ifdef IFU_FAULT_EN
                        inst_fault  <= 1'b1;
`endif
                        state       <= S_VALID;
                    end else if (accept) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rsp_valid) begin
`ifdef IFU_FAULT_EN
                        bus.inst   <= bus.imem_rsp_err ? XLEN'(NOP_INST) : bus.imem_rsp_data;
                        inst_fault <= bus.imem_rsp_err;
`else
                        bus.inst   <= bus.imem_rsp_data;
`endif
                        bus.inst_pc <= pc;
                        state       <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (fire) begin
                        pc        <= next_pc;
                        fetch_cnt <= fetch_cnt + 32'd1;
                        state     <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (bus.imem_rsp_valid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // A response with nothing outstanding means the memory broke the protocol;
    // the FSM ignores it.
    rsp_only_when_outstanding: assert property (@(posedge clk) disable iff (!rst)
        bus.imem_rsp_valid |-> (state == S_WAIT || state == S_DRAIN));

endmodule
